// File: rtl/reg_val_pkg.sv
// Shared constants, age-counter sizing and channel state type for the reg_val bank.
// The staleness timeout is compiled in only when REG_VAL_TIMEOUT_EN is defined.
package reg_val_pkg;

    localparam int DEF_WIDTH   = 9;
    localparam int DEF_NCH     = 4;
    localparam int DEF_TIMEOUT = 15;

    // Age counter must hold 0..TIMEOUT-1 without wrapping.
    function automatic int age_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    localparam int DEF_AGE_W = age_width(DEF_TIMEOUT);

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 valid;
        logic [DEF_AGE_W-1:0] age;
    } ch_state_t;

endpackage

// File: rtl/reg_val_ch.sv
// One channel of the bank: data register, valid flag and, with REG_VAL_TIMEOUT_EN,
// an age counter that expires the value and emits a one-cycle stale pulse.
module reg_val_ch
    import reg_val_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             stale_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

`ifdef REG_VAL_TIMEOUT_EN
    localparam int AW = age_width(TIMEOUT);

    logic [AW-1:0] age_q, age_d;
    logic          stale_q, stale_d;

    // Priority: load beats clear beats expiry.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        age_d   = age_q;
        stale_d = 1'b0;
        if (wr_en) begin
            data_d  = data_in;
            valid_d = 1'b1;
            age_d   = '0;
        end else if (clr) begin
            valid_d = 1'b0;
            age_d   = '0;
        end else if (valid_q) begin
            if (age_q == AW'(TIMEOUT - 1)) begin
                valid_d = 1'b0;
                age_d   = '0;
                stale_d = 1'b1;
            end else begin
                age_d = age_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            age_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            age_q   <= age_d;
            stale_q <= stale_d;
        end
    end

    assign stale_o = stale_q;
`else
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_en) begin
            data_d  = data_in;
            valid_d = 1'b1;
        end else if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign stale_o = 1'b0;
`endif

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/reg_val_bank.sv
// NCH-channel valid-tracked register bank with shared write port and registered read port.
// Define REG_VAL_TIMEOUT_EN to compile in per-channel staleness expiry.
module reg_val_bank
    import reg_val_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NCH     = DEF_NCH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [$clog2(NCH)-1:0]  wr_sel,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    clr_all,
    input  logic [$clog2(NCH)-1:0]  rd_sel,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic [NCH-1:0]          valid_vec,
    output logic [NCH-1:0]          stale_vec,
    output logic                    wr_err
);

    localparam int SW = $clog2(NCH);

    logic [WIDTH-1:0] ch_data [NCH];
    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   ch_stale;
    logic             wr_sel_ok;
    logic             rd_sel_ok;

    // Only reachable for non-power-of-2 NCH; otherwise these are constant true.
    assign wr_sel_ok = (int'(wr_sel) < NCH);
    assign rd_sel_ok = (int'(rd_sel) < NCH);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic wr_en;
            assign wr_en = load && wr_sel_ok && (wr_sel == SW'(gi));

            reg_val_ch #(
                .WIDTH   (WIDTH),
                .TIMEOUT (TIMEOUT)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en),
                .clr     (clr_all),
                .data_in (data_in),
                .data_o  (ch_data[gi]),
                .valid_o (ch_valid[gi]),
                .stale_o (ch_stale[gi])
            );
        end
    endgenerate

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             wr_err_q, wr_err_d;

    // Read samples pre-edge channel state, so a same-cycle write returns the old value.
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        if (rd_sel_ok) begin
            rd_data_d  = ch_data[rd_sel];
            rd_valid_d = ch_valid[rd_sel];
        end
        wr_err_d = load && !wr_sel_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_err    = wr_err_q;
    assign valid_vec = ch_valid;
    assign stale_vec = ch_stale;

endmodule
